// File: rtl/mem_access_unit.sv
// Memory access stage: issues loads/stores on a request/acknowledge data bus,
// stalls the pipeline while a transfer is outstanding and aligns/extends load data.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  input  logic              flush_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

  // A zero-width counter is not legal, so TIMEOUT=0 keeps a 1-bit stub.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d, kill_q, kill_d;
  logic [3:0]        sel_q, sel_d, op_q, op_d;
  logic [1:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       bwdata_q, bwdata_d, result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        is_load, is_store, is_half, is_word, misaligned, op_q_load;
  logic [1:0]  byte_lane, rd_lane;
  logic        half_hi, rd_hi;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    is_load    = mem_op_i inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    is_store   = mem_op_i inside {4'b1001, 4'b1010, 4'b1011};
    is_half    = mem_op_i inside {4'b0011, 4'b0100, 4'b1010};
    is_word    = mem_op_i inside {4'b0101, 4'b1011};
    misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
    op_q_load  = op_q inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    byte_lane  = BIG_ENDIAN ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
    half_hi    = BIG_ENDIAN ? ~mem_addr_i[1] : mem_addr_i[1];
    if (is_word) begin
      sel_c   = 4'b1111;
      wdata_c = reg2_i;
    end else if (is_half) begin
      sel_c   = half_hi ? 4'b1100 : 4'b0011;
      wdata_c = {2{reg2_i[15:0]}};
    end else begin
      sel_c   = 4'b0001 << byte_lane;
      wdata_c = {4{reg2_i[7:0]}};
    end
  end

  // Load extraction works from the latched op/offset so it cannot shift under a flush.
  always_comb begin
    rd_lane = BIG_ENDIAN ? ~lo_q : lo_q;
    rd_hi   = BIG_ENDIAN ? ~lo_q[1] : lo_q[1];
    case (rd_lane)
      2'd0:    rd_byte = bus_rdata_i[7:0];
      2'd1:    rd_byte = bus_rdata_i[15:8];
      2'd2:    rd_byte = bus_rdata_i[23:16];
      default: rd_byte = bus_rdata_i[31:24];
    endcase
    rd_half = rd_hi ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (op_q)
      4'b0001: load_val = {{24{rd_byte[7]}}, rd_byte};
      4'b0010: load_val = {24'd0, rd_byte};
      4'b0011: load_val = {{16{rd_half[15]}}, rd_half};
      4'b0100: load_val = {16'd0, rd_half};
      4'b0101: load_val = bus_rdata_i;
      default: load_val = result_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    bwdata_d   = bwdata_q;
    result_d   = result_q;
    err_d      = err_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    lo_d       = lo_q;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stall_o    = 1'b0;
    exc_adel_o = 1'b0;
    exc_ades_o = 1'b0;
    bus_err_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush_i && (is_load || is_store)) begin
          if (misaligned) begin
            exc_adel_o = is_load;
            exc_ades_o = is_store;
            wreg_o     = 1'b0;
          end else begin
            stall_o  = 1'b1;
            wreg_o   = 1'b0;
            state_d  = S_WAIT;
            req_d    = 1'b1;
            we_d     = is_store;
            sel_d    = sel_c;
            addr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
            bwdata_d = wdata_c;
            err_d    = 1'b0;
            kill_d   = 1'b0;
            cnt_d    = '0;
            op_d     = mem_op_i;
            lo_d     = mem_addr_i[1:0];
          end
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        wreg_o  = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        if (flush_i) kill_d = 1'b1;
        // Ack wins over a timeout expiring in the same cycle.
        if (bus_ack_i) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (op_q_load) result_d = load_val;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wdata_o   = result_q;
        wreg_o    = wreg_i && op_q_load && !err_q && !kill_q && !flush_i;
        bus_err_o = err_q && !kill_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      stall_o    = 1'b0;
      exc_adel_o = 1'b0;
      exc_ades_o = 1'b0;
      bus_err_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      bwdata_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      bwdata_q <= bwdata_d;
      result_q <= result_d;
      err_q    <= err_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      lo_q     <= lo_d;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = bwdata_q;
  assign state_o     = state_q;

endmodule
